// File: rtl/dmem_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
package dmem_pkg;
  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = WORD_W / BYTE_W;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: byte-enabled synchronous write, combinational read of the addressed word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [NUM_BYTES-1:0] be,
  output logic [WORD_W-1:0]    rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed wait states and alignment/range error check.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; the response is held stable until then.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output dmem_state_e          dbg_state
);
  localparam int                AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0]       DEPTH_WORDS = 30'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD    = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              accept, enter_resp, mem_we, cur_err, cur_we;
  logic [31:0]       cur_addr, cur_wdata;
  logic [3:0]        cur_be;
  logic [WORD_W-1:0] mem_rdata;

  // With zero wait states RESP is entered on the accept edge, so the live request is used there.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_WORDS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    accept     = req_valid && req_ready;
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage write and load capture both happen on the edge entering RESP; reset cancels a pending store.
  always_comb begin
    req_ready   = (state_q == S_IDLE) && !rst;
    mem_we      = enter_resp && cur_we && !cur_err && !rst;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err;
      rsp_rdata_d = (cur_err || cur_we) ? '0 : mem_rdata;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (mem_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset corner sequences, randomized traffic
// against a word-array reference model, and a zero-wait-state back-to-back instance.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int W     = 2;
  localparam int BOUND = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  dmem_state_e dbg_state;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;
  dmem_state_e z_dbg_state;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] ref_mem [int];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: no event seen, required within %0d cycles", name, BOUND);
  endtask

  // Reference model: memory as an array of words, rules applied directly.
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic err);
    logic [31:0] word;
    int idx;
    err = (addr % 4 != 0) || ((addr / 4) >= 1024);
    rd  = 32'h0;
    if (!err) begin
      idx  = int'(addr / 4);
      word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
        ref_mem[idx] = word;
      end else begin
        rd = word;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  // Returns just after the accept edge.
  task automatic wait_accept(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound({name, " accept"});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Latency counts the accept edge as 1; returns at the negedge where rsp_valid is seen.
  task automatic wait_rsp(input string name, output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    if (!ok) fail_bound({name, " response"});
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string name);
    logic [31:0] exp;
    logic exp_e;
    int lat;
    bit ok;
    exp   = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    drive_req(we, addr, wdata, be);
    wait_accept(name, ok);
    if (!ok) return;
    wait_rsp(name, lat, ok);
    if (!ok) return;
    check({name, " latency"}, 64'(lat), 64'(W + 1));
    check({name, " rdata"}, 64'(rsp_rdata), 64'(exp));
    check({name, " err"}, 64'(rsp_err), 64'(exp_e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " hold"}, 64'({rsp_valid, req_ready, rsp_err, rsp_rdata}),
            64'({1'b1, 1'b0, exp_e, exp}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({name, " after handshake"}, 64'({rsp_valid, rsp_err, req_ready, rsp_rdata}),
          64'({1'b0, 1'b0, 1'b1, 32'h0}));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_rd, wd, ad;
    logic e_er, we_r;
    logic [3:0] be_r;
    int lat, sel;
    bit ok;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h000000AA, 4'b0001, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b0, 32'h11,       32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h1000,     32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h11,       32'h12345678, 4'b1111, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'hDEADBEAA, 1'b0};
    vecs[8]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'hDEADBEAA, 1'b0};
    vecs[10] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'hFFC,      32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b1, 32'h10,       32'h11223344, 4'b1010, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'h11AD33AA, 1'b0};
    vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 32'h20,       32'h11111111, 4'b1111, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 32'h13,       32'h55555555, 4'b1111, 32'h0,        1'b1};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'h0);
    check("reset state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready after reset release", 64'(req_ready), 64'h1);

    // Directed table, with a 5-cycle response stall on vector 3
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(vecs[i].exp_rdata);
      exp_err_q.push_back(vecs[i].exp_err);
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, (i == 3) ? 5 : 0,
             $sformatf("vec%0d", i));
    end

    // Reset while a store to 0x20 waits: the store must be dropped
    @(posedge clk);
    #1 drive_req(1'b1, 32'h20, 32'h22222222, 4'b1111);
    wait_accept("rst_in_wait", ok);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_wait ready low", 64'(req_ready), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_wait outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'h0);
    check("rst_in_wait state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_wait ready after release", 64'(req_ready), 64'h1);
    exp_q.push_back(32'h11111111); exp_err_q.push_back(1'b0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, "load after dropped store");

    // Reset while a store response is pending: the write must persist
    @(posedge clk);
    #1 drive_req(1'b1, 32'h28, 32'h33333333, 4'b1111);
    wait_accept("rst_in_resp", ok);
    wait_rsp("rst_in_resp", lat, ok);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_resp outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(32'h33333333); exp_err_q.push_back(1'b0);
    do_req(1'b0, 32'h28, 32'h0, 4'h0, 0, "load after reset in resp");

    // Randomized traffic against the reference model
    for (int k = 0; k < 16; k++) begin
      ad = 32'h100 + 32'(k * 4);
      wd = $urandom();
      model_txn(1'b1, ad, wd, 4'hF, e_rd, e_er);
      exp_q.push_back(e_rd); exp_err_q.push_back(e_er);
      do_req(1'b1, ad, wd, 4'hF, 0, "rand init");
    end
    for (int k = 0; k < 120; k++) begin
      sel  = $urandom_range(0, 9);
      we_r = 1'($urandom_range(0, 1));
      wd   = $urandom();
      be_r = 4'($urandom_range(0, 15));
      if (sel == 0)      ad = 32'h100 + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (sel == 1) ad = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      else               ad = 32'h100 + 32'($urandom_range(0, 15) * 4);
      model_txn(we_r, ad, wd, be_r, e_rd, e_er);
      exp_q.push_back(e_rd); exp_err_q.push_back(e_er);
      do_req(we_r, ad, wd, be_r, $urandom_range(0, 2), $sformatf("rand%0d", k));
    end

    // Zero wait states: store then continuous loads, accept every other cycle
    @(posedge clk);
    #1;
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'hA5A55A5A;
    z_req_be = 4'hF; z_rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("zero_wait cycle%0d", i),
            64'({z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_rdata}),
            64'({(i % 2 == 0), (i % 2 == 1), 1'b0, ((i % 2 == 1) && (i > 1)) ? 32'hA5A55A5A : 32'h0}));
      @(posedge clk);
      #1;
      if (i == 0) z_req_we = 1'b0;
    end
    z_req_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The parameter DEPTH SHALL default to 1024 and give the storage size in 32-bit words.
REQ-002 The parameter WAIT_CYCLES SHALL default to 2 and give the wait states between request accept and response, range 0..15.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; every state change SHALL happen on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-005 Port req_valid, input, 1 bit, SHALL mean the core presents a request.
REQ-006 Port req_ready, output, 1 bit, SHALL mean the block can accept a request this cycle.
REQ-007 Port req_we, input, 1 bit, SHALL select store (1) or load (0).
REQ-008 Port req_addr, input, 32 bits, SHALL be the byte address.
REQ-009 Port req_wdata, input, 32 bits, SHALL be the store data.
REQ-010 Port req_be, input, 4 bits, SHALL be the store byte enables, bit i mapping to wdata[8i+7:8i].
REQ-011 Port rsp_valid, output, 1 bit, SHALL mean a response is presented.
REQ-012 Port rsp_ready, input, 1 bit, SHALL mean the core accepts the response.
REQ-013 Port rsp_rdata, output, 32 bits, SHALL be the load data; it SHALL be 0 for stores and errors.
REQ-014 Port rsp_err, output, 1 bit, SHALL flag a misaligned or out-of-range access.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; no more than one request SHALL ever be in flight.
REQ-017 Accept SHALL occur when req_valid and req_ready are both 1; req_we, req_addr, req_wdata and req_be SHALL then be latched.
REQ-018 After accept: WAIT_CYCLES>0 -> WAIT with counter loaded to WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP, so rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 Error SHALL be set when addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-021 Stores without error SHALL write only the enabled bytes, on the edge entering RESP; be=0 SHALL write nothing but still respond.
REQ-022 Loads without error SHALL return the full word at addr[31:2], sampled on the edge entering RESP.
REQ-023 Errored accesses SHALL never modify storage and SHALL return rsp_rdata=0 with rsp_err=1.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_ready=1.
REQ-025 The rsp_valid and rsp_ready handshake SHALL return the FSM to IDLE and clear rsp_valid, rsp_err and rsp_rdata on the same edge.
REQ-026 In the cycle after a response handshake req_ready SHALL be 1, allowing back-to-back requests with one idle cycle.
REQ-027 req_valid while not ready SHALL be ignored; the core holds the request until accepted.
REQ-028 A load that follows a store to the same word SHALL return the updated data.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-030 req_ready SHALL be 0 while rst is held and 1 in the first cycle after release.
REQ-031 Reset in WAIT SHALL drop the request, including any pending store, which SHALL never be written.
REQ-032 Reset in RESP SHALL drop the response; the already-written store SHALL persist.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-034 A shared package dmem_pkg SHALL hold the FSM state enum, the WAIT counter width constant (4) and the word/byte width constants.
REQ-035 A single sub-module dmem_array SHALL implement the DEPTH x 32 storage: synchronous byte-enabled write, read of the addressed word.
REQ-036 The FSM, counter, latches and error check SHALL live in data_mem_responder.

Verification
REQ-037 Store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after each accept.
REQ-038 Store 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF, then load 0x10 -> 0xDEADBEAA.
REQ-039 Load 0x11 and load 0x1000 with DEPTH=1024 -> err=1, rdata=0; store to 0x11 leaves memory unchanged.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0; handshake -> IDLE on the next cycle.
REQ-041 Assert rst in WAIT of a store to 0x20 -> a later load of 0x20 returns the prior value; all outputs are 0 during reset.
REQ-042 With WAIT_CYCLES=0, back-to-back loads and rsp_ready=1 -> rsp_valid 1 cycle after accept, and a new accept every 2 cycles.
